// File: rtl/wb_game_ctrl_pkg.sv
// Shared constants for the Wishbone game control block:
// register offsets, CTRL bit indices, STATUS field positions, decoder.
package wb_game_ctrl_pkg;

   localparam logic [7:0] REG_CTRL     = 8'h00;
   localparam logic [7:0] REG_DIFF     = 8'h04;
   localparam logic [7:0] REG_SW_INPUT = 8'h08;
   localparam logic [7:0] REG_STATUS   = 8'h0C;
   localparam logic [7:0] REG_SCORE    = 8'h10;
   localparam logic [7:0] REG_IRQ_STAT = 8'h14;

   localparam int CTRL_SOFT_RST    = 0;
   localparam int CTRL_DIFF_OVR    = 1;
   localparam int CTRL_SW_INPUT_EN = 2;
   localparam int CTRL_IRQ_EN      = 3;

   localparam int STAT_PAD_LSB  = 0;
   localparam int STAT_DIFF_LSB = 16;
   localparam int STAT_RST_BIT  = 31;

   typedef enum logic [2:0] {
      R_CTRL,
      R_DIFF,
      R_SW_INPUT,
      R_STATUS,
      R_SCORE,
      R_IRQ_STAT,
      R_NONE
   } reg_e;

   function automatic reg_e decode(input logic [7:0] off);
      case (off)
         REG_CTRL:     return R_CTRL;
         REG_DIFF:     return R_DIFF;
         REG_SW_INPUT: return R_SW_INPUT;
         REG_STATUS:   return R_STATUS;
         REG_SCORE:    return R_SCORE;
         REG_IRQ_STAT: return R_IRQ_STAT;
         default:      return R_NONE;
      endcase
   endfunction

endpackage

// File: rtl/wb_game_ctrl_sync2.sv
// Width-parametrised two-flop synchroniser, async active-low reset.
// Ports: clk, rst_n, d (async input), q (synchronised output).
module sync2
   import wb_game_ctrl_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= '0;
         q    <= '0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/wb_game_ctrl.sv
// Wishbone control/status bank between wrapper pads and game core.
// Ports: Wishbone slave, la_rst_i, pads, score_i; game_rst/player/difficulty/irq out.
module wb_game_ctrl
   import wb_game_ctrl_pkg::*;
#(
   parameter int          NUM_PLAYERS       = 2,
   parameter int          INPUTS_PER_PLAYER = 2,
   parameter int          DIFF_WIDTH        = 4,
   parameter int          SCORE_WIDTH       = 4,
   parameter logic [31:0] BASE_ADDR         = 32'h3000_0000,
   parameter int          SOFTRST_CYCLES    = 16
) (
   input  logic                                   wb_clk_i,
   input  logic                                   wb_rst_ni,
   input  logic                                   wbs_stb_i,
   input  logic                                   wbs_cyc_i,
   input  logic                                   wbs_we_i,
   input  logic [3:0]                             wbs_sel_i,
   input  logic [31:0]                            wbs_dat_i,
   input  logic [31:0]                            wbs_adr_i,
   output logic                                   wbs_ack_o,
   output logic [31:0]                            wbs_dat_o,
   input  logic                                   la_rst_i,
   input  logic [NUM_PLAYERS*INPUTS_PER_PLAYER-1:0] pad_in_i,
   input  logic [DIFF_WIDTH-1:0]                  pad_diff_i,
   input  logic [NUM_PLAYERS*SCORE_WIDTH-1:0]     score_i,
   output logic                                   game_rst_o,
   output logic [NUM_PLAYERS*INPUTS_PER_PLAYER-1:0] player_o,
   output logic [DIFF_WIDTH-1:0]                  difficulty_o,
   output logic                                   irq_o
);

   localparam int NPI = NUM_PLAYERS * INPUTS_PER_PLAYER;
   localparam int NSW = NUM_PLAYERS * SCORE_WIDTH;
   localparam int CW  = $clog2(SOFTRST_CYCLES + 1);

   if (NPI > 16) begin : g_chk_pads
      $error("NUM_PLAYERS*INPUTS_PER_PLAYER must be <= 16");
   end
   if (DIFF_WIDTH > 8) begin : g_chk_diff
      $error("DIFF_WIDTH must be <= 8");
   end
   if (NSW > 32) begin : g_chk_score
      $error("NUM_PLAYERS*SCORE_WIDTH must be <= 32");
   end
   if (SOFTRST_CYCLES < 1) begin : g_chk_rst
      $error("SOFTRST_CYCLES must be >= 1");
   end

   logic [NPI-1:0]         pad_sync;
   logic [NPI-1:0]         sw_input;
   logic [DIFF_WIDTH-1:0]  diff_sync;
   logic [DIFF_WIDTH-1:0]  diff_reg;
   logic                   diff_ovr;
   logic                   sw_en;
   logic                   irq_en;
   logic                   ack;
   logic [31:0]            dat;
   logic [31:0]            rdata;
   logic [31:0]            wmask;
   logic [CW-1:0]          cnt;
   logic [NSW-1:0]         score_prev;
   logic [NUM_PLAYERS-1:0] irq_stat;
   logic [NUM_PLAYERS-1:0] score_chg;
   logic [NUM_PLAYERS-1:0] irq_set;
   logic [NUM_PLAYERS-1:0] irq_clr;
   logic                   hit;
   logic                   req;
   logic                   wr;
   reg_e                   rsel;
   logic                   unused_bits;

   sync2 #(.WIDTH(NPI)) u_pad_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .d     (pad_in_i),
      .q     (pad_sync)
   );

   sync2 #(.WIDTH(DIFF_WIDTH)) u_diff_sync (
      .clk   (wb_clk_i),
      .rst_n (wb_rst_ni),
      .d     (pad_diff_i),
      .q     (diff_sync)
   );

   assign hit  = wbs_stb_i & wbs_cyc_i &
                 (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
   // Blocking on ack turns a held strobe into one ack every two cycles.
   assign req  = hit & ~ack;
   assign wr   = req & wbs_we_i;
   assign rsel = decode({wbs_adr_i[7:2], 2'b00});

   assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

   assign game_rst_o   = la_rst_i | (cnt != '0);
   assign player_o     = sw_en ? sw_input : pad_sync;
   assign difficulty_o = diff_ovr ? diff_reg : diff_sync;
   assign irq_o        = irq_en & (|irq_stat);
   assign wbs_ack_o    = ack;
   assign wbs_dat_o    = dat;

   assign unused_bits = ^{wbs_adr_i[1:0], wbs_dat_i, wmask};

   always_comb begin
      rdata = '0;
      case (rsel)
         R_CTRL: begin
            rdata[CTRL_SOFT_RST]    = game_rst_o;
            rdata[CTRL_DIFF_OVR]    = diff_ovr;
            rdata[CTRL_SW_INPUT_EN] = sw_en;
            rdata[CTRL_IRQ_EN]      = irq_en;
         end
         R_DIFF:     rdata[DIFF_WIDTH-1:0] = diff_reg;
         R_SW_INPUT: rdata[NPI-1:0] = sw_input;
         R_STATUS: begin
            rdata[STAT_PAD_LSB +: NPI]         = pad_sync;
            rdata[STAT_DIFF_LSB +: DIFF_WIDTH] = diff_sync;
            rdata[STAT_RST_BIT]                = game_rst_o;
         end
         R_SCORE:    rdata[NSW-1:0] = score_prev;
         R_IRQ_STAT: rdata[NUM_PLAYERS-1:0] = irq_stat;
         default:    rdata = '0;
      endcase
   end

   always_comb begin
      score_chg = '0;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
         score_chg[p] = score_i[p*SCORE_WIDTH +: SCORE_WIDTH] !=
                        score_prev[p*SCORE_WIDTH +: SCORE_WIDTH];
      end
   end

   // Score changes seen while the core is held in reset are dropped.
   assign irq_set = game_rst_o ? '0 : score_chg;
   assign irq_clr = (wr && rsel == R_IRQ_STAT) ?
                    (wbs_dat_i[NUM_PLAYERS-1:0] & wmask[NUM_PLAYERS-1:0]) : '0;

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         ack        <= 1'b0;
         dat        <= '0;
         cnt        <= '0;
         diff_ovr   <= 1'b0;
         sw_en      <= 1'b0;
         irq_en     <= 1'b0;
         diff_reg   <= '0;
         sw_input   <= '0;
         score_prev <= '0;
         irq_stat   <= '0;
      end else begin
         ack        <= req;
         dat        <= (req & ~wbs_we_i) ? rdata : '0;
         score_prev <= score_i;
         // Set is ORed after the clear so a same-cycle set wins.
         irq_stat   <= (irq_stat & ~irq_clr) | irq_set;
         if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
         if (wr) begin
            case (rsel)
               R_CTRL: begin
                  if (wbs_sel_i[0]) begin
                     // Reload only ever lengthens the pulse.
                     if (wbs_dat_i[CTRL_SOFT_RST]) begin
                        cnt <= CW'(SOFTRST_CYCLES);
                     end
                     diff_ovr <= wbs_dat_i[CTRL_DIFF_OVR];
                     sw_en    <= wbs_dat_i[CTRL_SW_INPUT_EN];
                     irq_en   <= wbs_dat_i[CTRL_IRQ_EN];
                  end
               end
               R_DIFF: begin
                  diff_reg <= (diff_reg & ~wmask[DIFF_WIDTH-1:0]) |
                              (wbs_dat_i[DIFF_WIDTH-1:0] &
                               wmask[DIFF_WIDTH-1:0]);
               end
               R_SW_INPUT: begin
                  sw_input <= (sw_input & ~wmask[NPI-1:0]) |
                              (wbs_dat_i[NPI-1:0] & wmask[NPI-1:0]);
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_game_ctrl.sv
// Self-checking bench for wb_game_ctrl (default parameters).
// Read expectations go through a queue and are checked when ack arrives.
module tb_wb_game_ctrl;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic        clk;
   logic        rst_n;
   logic        stb;
   logic        cyc;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] wdat;
   logic [31:0] adr;
   logic        ack;
   logic [31:0] rdat;
   logic        la_rst;
   logic [3:0]  pad_in;
   logic [3:0]  pad_diff;
   logic [7:0]  score;
   logic        game_rst;
   logic [3:0]  player;
   logic [3:0]  difficulty;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;
   int hi_total = 0;
   logic [31:0] exp_q[$];

   wb_game_ctrl dut (
      .wb_clk_i     (clk),
      .wb_rst_ni    (rst_n),
      .wbs_stb_i    (stb),
      .wbs_cyc_i    (cyc),
      .wbs_we_i     (we),
      .wbs_sel_i    (sel),
      .wbs_dat_i    (wdat),
      .wbs_adr_i    (adr),
      .wbs_ack_o    (ack),
      .wbs_dat_o    (rdat),
      .la_rst_i     (la_rst),
      .pad_in_i     (pad_in),
      .pad_diff_i   (pad_diff),
      .score_i      (score),
      .game_rst_o   (game_rst),
      .player_o     (player),
      .difficulty_o (difficulty),
      .irq_o        (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (game_rst) hi_total <= hi_total + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic wb_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b1;
      adr = a; wdat = d; sel = s;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0; we = 1'b0;
      chk("wr_ack", 32'(ok), 32'd1);
   endtask

   task automatic wb_read(input logic [31:0] a, input logic [31:0] e,
                          input string tag);
      logic ok;
      logic [31:0] want;
      ok = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0;
      adr = a; sel = 4'hF;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
      want = exp_q.pop_front();
      if (ok) chk(tag, rdat, want);
      else    chk({tag, "_ack"}, 32'd0, 32'd1);
      cyc = 1'b0; stb = 1'b0;
   endtask

   initial begin
      logic       seen;
      logic [3:0] pat;
      int         h0;

      rst_n = 1'b0; la_rst = 1'b0;
      stb = 1'b0; cyc = 1'b0; we = 1'b0;
      sel = 4'h0; wdat = '0; adr = '0;
      pad_in = '0; pad_diff = '0; score = '0;

      repeat (2) @(negedge clk);
      chk("rst_outs", {22'd0, game_rst, ack, player, difficulty, irq},
          32'd0);
      chk("rst_dat", rdat, 32'd0);
      la_rst = 1'b1;
      #1 chk("rst_la_pass", 32'(game_rst), 32'd1);
      @(negedge clk);
      la_rst = 1'b0;
      rst_n  = 1'b1;

      wb_read(BASE + 32'h00, 32'd0, "ctrl0");
      wb_read(BASE + 32'h04, 32'd0, "diff0");
      wb_read(BASE + 32'h08, 32'd0, "swin0");
      wb_read(BASE + 32'h0C, 32'd0, "stat0");
      wb_read(BASE + 32'h10, 32'd0, "score0");
      wb_read(BASE + 32'h14, 32'd0, "irq0");
      la_rst = 1'b1;
      wb_read(BASE + 32'h0C, 32'h8000_0000, "stat_la");
      wb_read(BASE + 32'h00, 32'h1, "ctrl_la");
      la_rst = 1'b0;

      wb_write(BASE + 32'h40, 32'hFFFF_FFFF, 4'hF);
      wb_read(BASE + 32'h40, 32'd0, "unmapped");

      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h100;
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         seen |= ack;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("foreign_noack", 32'(seen), 32'd0);

      @(negedge clk);
      pad_in = 4'b1010;
      @(negedge clk);
      chk("pad_lat1", 32'(player), 32'h0);
      @(negedge clk);
      chk("pad_lat2", 32'(player), 32'hA);
      wb_read(BASE + 32'h0C, 32'hA, "stat_pad");
      wb_write(BASE + 32'h08, 32'h5, 4'hF);
      wb_write(BASE + 32'h00, 32'h4, 4'hF);
      chk("sw_in", 32'(player), 32'h5);
      pad_in = 4'b0011;
      repeat (3) @(negedge clk);
      chk("sw_hold", 32'(player), 32'h5);

      wb_write(BASE + 32'h04, 32'h9, 4'hF);
      pad_diff = 4'h3;
      repeat (3) @(negedge clk);
      chk("diff_pad", 32'(difficulty), 32'h3);
      wb_write(BASE + 32'h00, 32'h6, 4'hF);
      chk("diff_ovr", 32'(difficulty), 32'h9);
      wb_write(BASE + 32'h04, 32'hC, 4'h0);
      wb_read(BASE + 32'h04, 32'h9, "diff_nosel");
      wb_read(BASE + 32'h0C, 32'h0003_0003, "stat_both");

      h0 = hi_total;
      wb_write(BASE + 32'h00, 32'h1, 4'hF);
      wb_read(BASE + 32'h00, 32'h1, "ctrl_rstbit");
      repeat (30) @(negedge clk);
      chk("srst_len", 32'(hi_total - h0), 32'd16);

      h0 = hi_total;
      wb_write(BASE + 32'h00, 32'h1, 4'hF);
      repeat (8) @(negedge clk);
      wb_write(BASE + 32'h00, 32'h1, 4'hF);
      repeat (40) @(negedge clk);
      chk("srst_ext", 32'(hi_total - h0), 32'd26);

      la_rst = 1'b1;
      #1 chk("la_now", 32'(game_rst), 32'd1);
      @(negedge clk);
      la_rst = 1'b0;

      wb_write(BASE + 32'h00, 32'h8, 4'hF);
      score = 8'h10;
      @(negedge clk);
      chk("irq_pin", 32'(irq), 32'd1);
      wb_read(BASE + 32'h14, 32'h2, "irq_p1");
      wb_read(BASE + 32'h10, 32'h10, "score_rd");

      fork
         wb_write(BASE + 32'h14, 32'h2, 4'hF);
         begin
            @(negedge clk);
            score = 8'h11;
         end
      join
      wb_read(BASE + 32'h14, 32'h1, "w1c_mix");
      fork
         wb_write(BASE + 32'h14, 32'h1, 4'hF);
         begin
            @(negedge clk);
            score = 8'h12;
         end
      join
      wb_read(BASE + 32'h14, 32'h1, "set_wins");
      wb_write(BASE + 32'h14, 32'h1, 4'hF);
      wb_read(BASE + 32'h14, 32'h0, "w1c_clr");
      chk("irq_low", 32'(irq), 32'd0);

      wb_write(BASE + 32'h00, 32'h9, 4'hF);
      score = 8'h22;
      repeat (3) @(negedge clk);
      wb_read(BASE + 32'h14, 32'h0, "irq_in_rst");
      repeat (25) @(negedge clk);
      wb_read(BASE + 32'h14, 32'h0, "irq_after_rst");
      chk("irq_none", 32'(irq), 32'd0);

      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE;
      pat[3] = ack;
      for (int i = 2; i >= 0; i--) begin
         @(negedge clk);
         pat[i] = ack;
      end
      cyc = 1'b0; stb = 1'b0;
      chk("held_stb", 32'(pat), 32'h5);
      repeat (2) @(negedge clk);

      score = 8'h23;
      @(negedge clk);
      chk("irq_pre", 32'(irq), 32'd1);
      wb_write(BASE + 32'h00, 32'h9, 4'hF);
      @(negedge clk);
      cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h14;
      @(negedge clk);
      chk("mid_ack", 32'(ack), 32'd1);
      rst_n = 1'b0;
      score = 8'h00;
      #1 chk("mid_clr", {29'd0, ack, game_rst, irq}, 32'd0);
      chk("mid_dat", rdat, 32'd0);
      repeat (2) @(negedge clk);
      cyc = 1'b0; stb = 1'b0;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         seen |= ack;
      end
      chk("no_stale", 32'(seen), 32'd0);
      wb_read(BASE + 32'h14, 32'h0, "irq_cleared");
      wb_read(BASE + 32'h00, 32'h0, "ctrl_cleared");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
